seq_nr_divider: RTL and testbench
=================================

// Module: seq_nr_divider
// PURPOSE
//   Iterative unsigned non-restoring divider. One shared WIDTH+1-bit add/sub datapath is
//   reused once per cycle: add or subtract, selected by the sign of the partial remainder.
//   It is the inverse companion of the CLA add/sub arithmetic blocks: it recovers
//   quotient/remainder from a dividend. Valid/ready handshake on both sides, so it can
//   sit between pipeline stages of the ALU path.
// PARAMETERS
//   WIDTH  4  operand, quotient and remainder width in bits (>=2)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      dividend/divisor valid
//   in_ready     out  1      divider idle and able to accept operands
//   dividend     in   WIDTH  unsigned dividend
//   divisor      in   WIDTH  unsigned divisor
//   out_valid    out  1      quotient/remainder/div_by_zero valid
//   out_ready    in   1      downstream accepts the result
//   quotient     out  WIDTH  unsigned quotient
//   remainder    out  WIDTH  unsigned remainder, always < divisor when divisor != 0
//   div_by_zero  out  1      set when the accepted divisor was 0
// BEHAVIOUR
//   - Reset: state=IDLE. quotient, remainder, div_by_zero and out_valid are all 0.
//     in_ready=1 (decoded from IDLE). rst mid-operation aborts the division and discards
//     the result; it takes priority over every other event.
//   - States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE), out_valid = (state==DONE).
//   - IDLE: in_valid&in_ready at edge E0 latches the operands. A 0 divisor goes to DONE
//     with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, so out_valid is high
//     1 cycle after E0. Otherwise: P=0 (WIDTH+1 bits, signed), Q=dividend, cnt=0, -> CALC.
//   - CALC, one step per cycle, WIDTH cycles:
//     {P,Q} <<= 1;
//     P = P[WIDTH] ? P + {1'b0,D} : P - {1'b0,D};
//     Q[0] = ~P_new[WIDTH].
//     After cnt==WIDTH-1 -> FIX.
//   - FIX (1 cycle): if P<0 then P += D. Then quotient=Q, remainder=P[WIDTH-1:0],
//     div_by_zero=0, -> DONE.
//   - Latency: out_valid rises WIDTH+1 cycles after the acceptance edge (divisor!=0).
//     Constant; it does not depend on the operand values.
//   - DONE: outputs are held stable while out_ready=0. out_valid&out_ready -> IDLE. No
//     same-cycle re-accept: in_ready rises the cycle after the output handshake.
//   - in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
//   - All arithmetic is modulo 2^(WIDTH+1) on P. Q and the outputs are WIDTH bits, and no
//     overflow is possible for unsigned operands.
//   - All outputs are registered and nothing is combinational from in_* to out_*, with
//     one exception: in_ready is decoded from state.
// TESTING (WIDTH=4)
//   1. 13/3 -> after 5 cycles out_valid=1, q=4, r=1, dbz=0; in_ready=0 during CALC/FIX.
//   2. 15/1 -> q=15, r=0. 2/9 -> q=0, r=2. 0/5 -> q=0, r=0. Each has 5-cycle latency.
//   3. 7/0 -> 1 cycle later out_valid=1, q=15, r=7, dbz=1.
//   4. 13/3 with out_ready low 10 cycles -> outputs frozen at q=4, r=1; in_valid pulses
//      ignored; in_ready=1 the cycle after out_ready is raised.
//   5. rst asserted on 3rd CALC cycle of 14/5 -> next cycle IDLE, out_valid=0, q=r=0,
//      in_ready=1; then 14/5 -> q=2, r=4.
//   6. Exhaustive 256 pairs (incl. divisor 0) against q=a/b, r=a%b reference, random
//      out_ready stall.

Source files
------------

// File: rtl/seq_nr_divider_if.sv
// Handshake bundle for the iterative divider: operand channel in, result channel out.
// The master drives operands and consumes results; the slave is the divider itself.
interface seq_nr_divider_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid,
        input  in_ready,
        output dividend,
        output divisor,
        input  out_valid,
        output out_ready,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  dividend,
        input  divisor,
        output out_valid,
        input  out_ready,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// Iterative unsigned non-restoring divider: one WIDTH+1-bit add/sub per cycle,
// WIDTH quotient steps plus one remainder-correction cycle, valid/ready on both sides.
module seq_nr_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_nr_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Shared add/sub datapath, used by both the CALC steps and the FIX correction.
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   alu_a;
    logic             alu_add;
    logic [WIDTH:0]   alu_sum;

    always_comb begin
        d_ext   = {1'b0, d_q};
        p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_shift = {q_q[WIDTH-2:0], 1'b0};
        // Add/sub choice uses the sign of P before the shift; the shift itself may wrap.
        alu_a   = (state_q == FIX) ? p_q : p_shift;
        alu_add = (state_q == FIX) ? 1'b1 : p_q[WIDTH];
        alu_sum = alu_add ? (alu_a + d_ext) : (alu_a - d_ext);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        p_d     = '0;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                p_d   = alu_sum;
                q_d   = {q_shift[WIDTH-1:1], ~alu_sum[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (p_q[WIDTH]) begin
                    p_d = alu_sum;
                end
                quot_d  = q_q;
                rem_d   = p_q[WIDTH] ? alu_sum[WIDTH-1:0] : p_q[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed and exhaustive checks of seq_nr_divider (WIDTH=4) against an
// arithmetic model of the handshake/latency behaviour plus literal expectations.
module tb_seq_nr_divider;
    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic clk;
    logic rst;
    int   tests;
    int   errors;
    bit   chk_en;

    seq_nr_divider_if #(.WIDTH(W)) bus ();

    seq_nr_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: idle flag, countdown to result, and the result computed with / and %.
    bit           m_idle;
    bit           m_valid;
    int           m_cd;
    logic [W-1:0] m_q, m_r, m_pq, m_pr;
    logic         m_dbz;

    always @(posedge clk) begin
        if (rst) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_cd    <= 0;
            m_q     <= '0;
            m_r     <= '0;
            m_dbz   <= 1'b0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                m_idle <= 1'b0;
                if (bus.divisor == 0) begin
                    m_valid <= 1'b1;
                    m_q     <= '1;
                    m_r     <= bus.dividend;
                    m_dbz   <= 1'b1;
                end else begin
                    m_cd <= LAT;
                    m_pq <= bus.dividend / bus.divisor;
                    m_pr <= bus.dividend % bus.divisor;
                end
            end
        end else if (m_cd > 0) begin
            m_cd <= m_cd - 1;
            if (m_cd == 1) begin
                m_valid <= 1'b1;
                m_q     <= m_pq;
                m_r     <= m_pr;
                m_dbz   <= 1'b0;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_in_ready", int'(bus.in_ready), int'(m_idle));
            check("mdl_out_valid", int'(bus.out_valid), int'(m_valid));
            if (m_valid && bus.out_valid) begin
                check("mdl_quotient", int'(bus.quotient), int'(m_q));
                check("mdl_remainder", int'(bus.remainder), int'(m_r));
                check("mdl_dbz", int'(bus.div_by_zero), int'(m_dbz));
            end
        end
    end

    // One division transaction; lat = edges after acceptance until out_valid is seen.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int elat, input bit pulse);
        int lat;
        int busy_ready;
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL idle_timeout: in_ready stuck at 0 before %0d/%0d", a, b);
            return;
        end
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        lat = 0;
        busy_ready = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("busy_in_ready", busy_ready, 0);
        check("quotient", int'(bus.quotient), int'(eq));
        check("remainder", int'(bus.remainder), int'(er));
        check("div_by_zero", int'(bus.div_by_zero), int'(edbz));
        for (int s = 0; s < stall; s++) begin
            if (pulse) begin
                bus.in_valid = s[0];
                bus.dividend = 4'd9;
                bus.divisor  = 4'd2;
            end
            @(posedge clk); #1;
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_quotient", int'(bus.quotient), int'(eq));
            check("stall_remainder", int'(bus.remainder), int'(er));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", int'(bus.in_ready), 1);
        check("post_hs_out_valid", int'(bus.out_valid), 0);
        $display("[TB] %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d stall=%0d",
                 a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, stall);
    endtask

    initial begin
        tests         = 0;
        errors        = 0;
        chk_en        = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(4'd13, 4'd3, 0, 4'd4, 4'd1, 1'b0, LAT, 1'b0);
        do_div(4'd15, 4'd1, 0, 4'd15, 4'd0, 1'b0, LAT, 1'b0);
        do_div(4'd2, 4'd9, 0, 4'd0, 4'd2, 1'b0, LAT, 1'b0);
        do_div(4'd0, 4'd5, 0, 4'd0, 4'd0, 1'b0, LAT, 1'b0);
        do_div(4'd7, 4'd0, 0, 4'd15, 4'd7, 1'b1, 0, 1'b0);
        do_div(4'd13, 4'd3, 10, 4'd4, 4'd1, 1'b0, LAT, 1'b1);

        // Reset sampled at the edge ending the third CALC cycle of 14/5.
        bus.in_valid = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 4'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        $display("[TB] 14/5 aborted by rst -> in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);
        do_div(4'd14, 4'd5, 0, 4'd2, 4'd4, 1'b0, LAT, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] av, bv, eq, er;
                av = W'(a);
                bv = W'(b);
                eq = (b == 0) ? 4'd15 : W'(a / b);
                er = (b == 0) ? av : W'(a % b);
                do_div(av, bv, int'($urandom_range(0, 3)), eq, er, (b == 0),
                       (b == 0) ? 0 : LAT, 1'b0);
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
